// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: EX redirect, stall/ready/accelerator controls in; PC, fetch and flush controls out.
interface pc_sequencer_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic              ex_valid;
    logic              ex_pc_src;
    logic [XLEN-1:0]   ex_new_pc;
    logic              stall;
    logic              if_ready;
    logic              acc_busy;
    logic              trap_ack;

    logic [XLEN-1:0]   pc;
    logic              fetch_valid;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              misalign_trap;
    logic [XLEN-1:0]   bad_target;
    logic [CNT_W-1:0]  redirect_cnt;

    // Sequencer side
    modport master (
        input  ex_valid, ex_pc_src, ex_new_pc, stall, if_ready, acc_busy, trap_ack,
        output pc, fetch_valid, flush_if_id, flush_id_ex, misalign_trap, bad_target, redirect_cnt
    );

    // Pipeline / environment side
    modport slave (
        output ex_valid, ex_pc_src, ex_new_pc, stall, if_ready, acc_busy, trap_ack,
        input  pc, fetch_valid, flush_if_id, flush_id_ex, misalign_trap, bad_target, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC register and fetch sequencer: applies EX redirects, stalls and accelerator holds,
// suppresses fetch after redirects and traps on misaligned redirect targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC      = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.master ctl_io
);
    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FCNT_W  = 4;
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [XLEN-1:0]    bad_target_q, bad_target_d;
    logic [CNT_W-1:0]   redirect_cnt_q, redirect_cnt_d;

    logic               redir;
    logic               aligned;
    logic [CNT_W-1:0]   cnt_inc;
    logic               fetch_valid_c;
    logic               flush_c;

    assign redir   = ctl_io.ex_valid & ctl_io.ex_pc_src;
    assign aligned = (ctl_io.ex_new_pc[1:0] == 2'b00);
    assign cnt_inc = (redirect_cnt_q == {CNT_W{1'b1}}) ? redirect_cnt_q
                                                       : redirect_cnt_q + CNT_W'(1);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            fcnt_q         <= '0;
            bad_target_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            fcnt_q         <= fcnt_d;
            bad_target_q   <= bad_target_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    // Next-state, PC update and fetch-valid; redirect has priority over acc_busy, stall, advance
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fcnt_d         = fcnt_q;
        bad_target_d   = bad_target_q;
        redirect_cnt_d = redirect_cnt_q;
        fetch_valid_c  = 1'b0;
        flush_c        = redir & (state_q != ST_TRAP);

        unique case (state_q)
            ST_RUN: begin
                fetch_valid_c = ~ctl_io.acc_busy;
                if (redir) begin
                    if (aligned) begin
                        pc_d           = ctl_io.ex_new_pc;
                        redirect_cnt_d = cnt_inc;
                        if (FLUSH_CYCLES != 0) begin
                            state_d = ST_FLUSH;
                            fcnt_d  = FLUSH_LOAD;
                        end
                    end else begin
                        pc_d         = TRAP_PC;
                        bad_target_d = ctl_io.ex_new_pc;
                        state_d      = ST_TRAP;
                    end
                end else if (ctl_io.acc_busy) begin
                    state_d = ST_HOLD;
                end else if (!ctl_io.stall && ctl_io.if_ready) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end

            ST_FLUSH: begin
                if (redir) begin
                    if (aligned) begin
                        pc_d           = ctl_io.ex_new_pc;
                        redirect_cnt_d = cnt_inc;
                        fcnt_d         = FLUSH_LOAD;
                    end else begin
                        pc_d         = TRAP_PC;
                        bad_target_d = ctl_io.ex_new_pc;
                        state_d      = ST_TRAP;
                    end
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                    if (fcnt_q <= FCNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_HOLD: begin
                if (redir) begin
                    if (aligned) begin
                        pc_d           = ctl_io.ex_new_pc;
                        redirect_cnt_d = cnt_inc;
                    end else begin
                        pc_d         = TRAP_PC;
                        bad_target_d = ctl_io.ex_new_pc;
                        state_d      = ST_TRAP;
                    end
                end else if (!ctl_io.acc_busy) begin
                    state_d = ST_RUN;
                end
            end

            ST_TRAP: begin
                pc_d = TRAP_PC;
                if (ctl_io.trap_ack) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Output drive; 1-bit controls forced low while reset is asserted
    assign ctl_io.pc            = pc_q;
    assign ctl_io.bad_target    = bad_target_q;
    assign ctl_io.redirect_cnt  = redirect_cnt_q;
    assign ctl_io.fetch_valid   = fetch_valid_c & ~rst;
    assign ctl_io.flush_if_id   = flush_c & ~rst;
    assign ctl_io.flush_id_ex   = flush_c & ~rst;
    assign ctl_io.misalign_trap = (state_q == ST_TRAP) & ~rst;
endmodule
